// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between the fetch port and the load/store port.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over fetch.
module mem_arbiter #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_gnt,
  output logic          o_if_rvalid,
  output logic [DW-1:0] o_if_rdata,
  input  logic          i_dm_req,
  input  logic          i_dm_we,
  input  logic [AW-1:0] i_dm_addr,
  input  logic [DW-1:0] i_dm_wdata,
  output logic          o_dm_gnt,
  output logic          o_dm_rvalid,
  output logic [DW-1:0] o_dm_rdata,
  output logic          o_ram_en,
  output logic          o_ram_we,
  output logic [AW-1:0] o_ram_addr,
  output logic [DW-1:0] o_ram_wdata,
  input  logic [DW-1:0] i_ram_rdata,
  output logic          o_busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          win_dm_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] if_rdata_q, dm_rdata_q;
  logic          any_req;
  logic          pick_dm;

  assign any_req = i_if_req | i_dm_req;

`ifdef MEM_ARB_RR_EN
  // Remembers whether the most recent grant went to the data port; fetch after reset.
  logic last_dm_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_dm_q <= 1'b0;
    end else if (state_q == StIssue) begin
      last_dm_q <= win_dm_q;
    end
  end

  assign pick_dm = i_dm_req & (~i_if_req | ~last_dm_q);
`else
  assign pick_dm = i_dm_req;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StIssue;
      StIssue: begin
        if (we_q) begin
          state_d = StIdle;
        end else begin
          state_d = StWait;
          cnt_d   = 4'(RD_LAT);
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_if_gnt    = 1'b0;
    o_dm_gnt    = 1'b0;
    o_if_rvalid = 1'b0;
    o_dm_rvalid = 1'b0;
    o_ram_en    = 1'b0;
    o_ram_we    = 1'b0;
    unique case (state_q)
      StIssue: begin
        o_ram_en = 1'b1;
        o_ram_we = we_q;
        o_if_gnt = ~win_dm_q;
        o_dm_gnt = win_dm_q;
      end
      StResp: begin
        o_if_rvalid = ~win_dm_q;
        o_dm_rvalid = win_dm_q;
      end
      default: ;
    endcase
  end

  // Winner fields are latched once in IDLE; wdata is forced to zero for reads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      win_dm_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (state_q == StIdle && any_req) begin
      win_dm_q <= pick_dm;
      we_q     <= pick_dm & i_dm_we;
      addr_q   <= pick_dm ? i_dm_addr : i_if_addr;
      wdata_q  <= (pick_dm & i_dm_we) ? i_dm_wdata : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else if (state_q == StWait && cnt_q == 4'd1) begin
      if (win_dm_q) dm_rdata_q <= i_ram_rdata;
      else          if_rdata_q <= i_ram_rdata;
    end
  end

  assign o_if_rdata  = if_rdata_q;
  assign o_dm_rdata  = dm_rdata_q;
  assign o_ram_addr  = addr_q;
  assign o_ram_wdata = wdata_q;
  assign o_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model plus directed literal checks.
// Honours MEM_ARB_RR_EN for the expected arbitration order.
module tb_mem_arbiter;

  localparam int unsigned Lat  = 1;
  localparam int unsigned Lat3 = 3;
`ifdef MEM_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic        clk, rst_n;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid;
  logic [31:0] if_rdata, dm_rdata;
  logic        ram_en, ram_we, busy;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  logic        dm3_req;
  logic [31:0] dm3_addr, ram3_rdata;
  logic        if3_gnt, if3_rvalid, dm3_gnt, dm3_rvalid, ram3_en, ram3_we, busy3;
  logic [31:0] if3_rdata, dm3_rdata, ram3_addr, ram3_wdata;

  int n_chk, n_err;
  logic [31:0] mem  [16];
  logic [31:0] mmem [16];

  mem_arbiter #(.AW(32), .DW(32), .RD_LAT(Lat)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid),
    .o_if_rdata(if_rdata),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
    .o_dm_gnt(dm_gnt), .o_dm_rvalid(dm_rvalid), .o_dm_rdata(dm_rdata),
    .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata), .o_busy(busy)
  );

  mem_arbiter #(.AW(32), .DW(32), .RD_LAT(Lat3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(1'b0), .i_if_addr(32'h0), .o_if_gnt(if3_gnt), .o_if_rvalid(if3_rvalid),
    .o_if_rdata(if3_rdata),
    .i_dm_req(dm3_req), .i_dm_we(1'b0), .i_dm_addr(dm3_addr), .i_dm_wdata(32'h0),
    .o_dm_gnt(dm3_gnt), .o_dm_rvalid(dm3_rvalid), .o_dm_rdata(dm3_rdata),
    .o_ram_en(ram3_en), .o_ram_we(ram3_we), .o_ram_addr(ram3_addr), .o_ram_wdata(ram3_wdata),
    .i_ram_rdata(ram3_rdata), .o_busy(busy3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    if_req = 1'b0;
    dm_req = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM with RD_LAT=1 for the main instance; returns noise when no read was issued.
  initial begin
    forever begin
      @(posedge clk);
      if (ram_en && ram_we) mem[ram_addr[5:2]] <= ram_wdata;
      ram_rdata <= (ram_en && !ram_we) ? mem[ram_addr[5:2]] : $urandom;
    end
  end

  // Reference model: one transaction at a time, events scheduled relative to the accept cycle.
  initial begin : model
    bit act, w_dm, w_we, last_dm, idle_now, pick_dm;
    int cyc, t0, rel;
    logic [31:0] w_addr, w_wdata, w_rdata, e_addr, e_ifd, e_dmd, e_wd;
    logic e_ig, e_dg, e_iv, e_dv, e_en, e_we, e_busy;
    act = 0; last_dm = 0; cyc = 0; t0 = 0; rel = 0;
    w_dm = 0; w_we = 0; w_addr = 0; w_wdata = 0; w_rdata = 0;
    e_addr = 0; e_ifd = 0; e_dmd = 0;
    wait (rst_n === 1'b0);
    forever begin
      @(negedge clk);
      cyc++;
      {e_ig, e_dg, e_iv, e_dv, e_en, e_we, e_busy} = '0;
      e_wd = 0;
      idle_now = 1'b0;
      if (!rst_n) begin
        act = 0; last_dm = 0; e_addr = 0; e_ifd = 0; e_dmd = 0;
      end else begin
        idle_now = !act;
        if (act) begin
          rel = cyc - t0;
          e_busy = 1'b1;
          if (rel == 1) begin
            e_en = 1'b1; e_we = w_we; e_wd = w_we ? w_wdata : 32'h0; e_addr = w_addr;
            if (w_dm) e_dg = 1'b1; else e_ig = 1'b1;
            if (w_we) mmem[w_addr[5:2]] = w_wdata;
          end
          if (!w_we && rel == 2 + Lat) begin
            if (w_dm) begin e_dv = 1'b1; e_dmd = w_rdata; end
            else      begin e_iv = 1'b1; e_ifd = w_rdata; end
          end
        end
      end
      chk("if_gnt", if_gnt, e_ig);
      chk("dm_gnt", dm_gnt, e_dg);
      chk("if_rvalid", if_rvalid, e_iv);
      chk("dm_rvalid", dm_rvalid, e_dv);
      chk("if_rdata", if_rdata, e_ifd);
      chk("dm_rdata", dm_rdata, e_dmd);
      chk("ram_en", ram_en, e_en);
      chk("ram_we", ram_we, e_we);
      chk("ram_addr", ram_addr, e_addr);
      if (e_en || !rst_n) chk("ram_wdata", ram_wdata, e_wd);
      chk("busy", busy, e_busy);
      if (rst_n) begin
        if (act && rel == (w_we ? 1 : 2 + Lat)) act = 0;
        if (idle_now && (if_req || dm_req)) begin
          pick_dm = dm_req && (!if_req || !RrEn || !last_dm);
          act = 1; t0 = cyc; w_dm = pick_dm; w_we = pick_dm && dm_we;
          w_addr = pick_dm ? dm_addr : if_addr;
          w_wdata = dm_wdata;
          w_rdata = mmem[w_addr[5:2]];
          last_dm = pick_dm;
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] v;
    bit ig, dg;
    int ng;
    bit order [4];
    n_chk = 0; n_err = 0;
    rst_n = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    dm3_req = 0; dm3_addr = 0; ram3_rdata = 0;
    for (int i = 0; i < 16; i++) begin
      v = $urandom; mem[i] = v; mmem[i] = v;
    end
    mem[4] = 32'hDEAD_BEEF; mmem[4] = 32'hDEAD_BEEF;
    #1 rst_n = 1'b0;

    // Reset with random requests: everything quiet.
    for (int i = 0; i < 4; i++) begin
      step();
      if_req = 1'($urandom); if_addr = $urandom;
      dm_req = 1'($urandom); dm_we = 1'($urandom); dm_addr = $urandom; dm_wdata = $urandom;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_gnt", {if_gnt, dm_gnt}, 0);
    end
    step();
    rst_n = 1'b1; if_req = 0; dm_req = 1; dm_we = 0; dm_addr = $urandom;
    @(negedge clk);
    chk("rel_busy", busy, 0);
    chk("rel_outs", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, ram_en, ram_we}, 0);
    step();
    step();
    idle(8);

    // RD_LAT=3 data read: rvalid at cycle 5, busy cycles 1..5.
    for (int k = 0; k < 8; k++) begin
      dm3_req = (k <= 1); dm3_addr = 32'h8;
      ram3_rdata = (k == 4) ? 32'h1234 : ($urandom | 32'h8000_0000);
      @(negedge clk);
      chk("t4_busy", busy3, (k >= 1 && k <= 5));
      chk("t4_gnt", dm3_gnt, (k == 1));
      chk("t4_rvalid", dm3_rvalid, (k == 5));
      if (k == 5) chk("t4_rdata", dm3_rdata, 32'h1234);
      step();
    end

    // Single fetch read.
    for (int k = 0; k < 6; k++) begin
      if_req = (k <= 1); if_addr = 32'h10;
      @(negedge clk);
      chk("t2_gnt", if_gnt, (k == 1));
      chk("t2_en", ram_en, (k == 1));
      if (k == 1) chk("t2_addr", ram_addr, 32'h10);
      chk("t2_rvalid", if_rvalid, (k == 3));
      if (k == 3) chk("t2_rdata", if_rdata, 32'hDEAD_BEEF);
      step();
    end

    // Contention: dm write wins, fetch follows once the write completes.
    for (int k = 0; k < 8; k++) begin
      dm_req = (k <= 1); dm_we = 1; dm_addr = 32'h20; dm_wdata = 32'h5A5A;
      if_req = (k <= 3); if_addr = 32'h4;
      @(negedge clk);
      chk("t3_dm_gnt", dm_gnt, (k == 1));
      chk("t3_we", ram_we, (k == 1));
      chk("t3_if_gnt", if_gnt, (k == 3));
      if (k == 3) chk("t3_addr", ram_addr, 32'h4);
      chk("t3_dm_rvalid", dm_rvalid, 0);
      step();
    end
    idle(4);

    // Continuous contention: grant order.
    ng = 0;
    for (int k = 0; k < 40 && ng < 4; k++) begin
      dm_req = 1; dm_we = 0; dm_addr = 32'h8; if_req = 1; if_addr = 32'hC;
      @(negedge clk);
      if (if_gnt) begin order[ng] = 1'b0; ng++; end
      else if (dm_gnt) begin order[ng] = 1'b1; ng++; end
      if (ng < 4) step();
    end
    chk("t5_count", ng, 4);
    for (int i = 0; i < 4; i++) chk("t5_order", order[i], RrEn ? (i % 2 == 0) : 1'b1);
    step();
    idle(8);

    // Reset pulse during WAIT aborts the read.
    for (int k = 0; k < 8; k++) begin
      rst_n = (k != 2);
      if_req = (k <= 1) || (k == 3);
      if_addr = (k <= 1) ? 32'h10 : 32'h30;
      @(negedge clk);
      chk("t6_rvalid", if_rvalid, (k == 6));
      chk("t6_gnt", if_gnt, (k == 1) || (k == 4));
      if (k == 2 || k == 3) chk("t6_busy", busy, 0);
      step();
    end
    idle(6);

    // Randomised traffic with legal requester behaviour and rare resets.
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      ig = if_gnt; dg = dm_gnt;
      step();
      rst_n = ($urandom_range(0, 299) != 0);
      if (!if_req || ig) begin
        if_req = ($urandom_range(0, 2) != 0); if_addr = $urandom;
      end
      if (!dm_req || dg) begin
        dm_req = ($urandom_range(0, 2) != 0); dm_we = 1'($urandom);
        dm_addr = $urandom; dm_wdata = $urandom;
      end
    end
    rst_n = 1'b1;
    idle(10);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
